// File: rtl/hit_manager.sv
// hit_manager
// Turns the raw ship/asteroid collision level into one-cycle life-loss pulses.
// After each hit the ship stays invulnerable for INVULN_TICKS frame ticks, so a
// single overlap costs exactly one life. It also drives the ship visibility
// (blink) and game-over flags used by the video path.
//
// Optional feature macro: HIT_BLINK_EN
//   defined   : ship_visible blinks while invulnerable, with a half-period of
//               BLINK_TICKS ticks, starting hidden.
//   undefined : ship_visible stays 1 for the whole invulnerable period, and
//               BLINK_TICKS has no effect.
//
// Ports
//   clock        in  rising-edge clock
//   clr          in  synchronous active-high reset, highest priority
//   start        in  new-game request (IDLE/OVER -> ARMED)
//   tick         in  one-cycle frame strobe
//   collision    in  level, ship overlaps an asteroid
//   lives_zero   in  level, lives counter is at zero
//   dec_pulse    out one-cycle life-loss pulse (lives counter enable)
//   invuln       out high while invulnerable
//   ship_visible out ship draw enable
//   game_over    out high in OVER
//   state        out FSM state for debug (IDLE=00 ARMED=01 INVULN=10 OVER=11)

module hit_manager #(
  parameter int INVULN_TICKS = 120,
  parameter int BLINK_TICKS  = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       start,
  input  logic       tick,
  input  logic       collision,
  input  logic       lives_zero,
  output logic       dec_pulse,
  output logic       invuln,
  output logic       ship_visible,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    INVULN = 2'b10,
    OVER   = 2'b11
  } state_e;

  // Parameter range guards, evaluated at elaboration.
  if (INVULN_TICKS < 1 || INVULN_TICKS > (2 ** CNT_W) - 1) begin : g_bad_invuln
    $error("hit_manager: INVULN_TICKS outside 1..2^CNT_W-1");
  end
  if (BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_blink
    $error("hit_manager: BLINK_TICKS outside 1..255");
  end

  state_e           state_q, state_d;
  logic             dec_pulse_q, dec_pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vis_q, vis_d;

`ifdef HIT_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);
  logic [7:0] blink_q, blink_d;
`endif

  // Main FSM and invulnerability counter.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dec_pulse_d = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        // An empty lives count ends the game even if the ship is hit this cycle.
        if (lives_zero) begin
          state_d = OVER;
        end else if (collision) begin
          state_d     = INVULN;
          dec_pulse_d = 1'b1;
          cnt_d       = CNT_W'(INVULN_TICKS);
        end
      end
      INVULN: begin
        // lives_zero is tested before the exit tick, so the decrement from the
        // last life (visible two cycles after the hit) always reaches OVER.
        if (lives_zero) begin
          state_d = OVER;
        end else if (tick) begin
          // <= 1 rather than == 1 keeps the counter from wrapping below zero.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      OVER: begin
        if (start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ship visibility, registered so the video path sees a clean Moore output.
  always_comb begin
    vis_d = 1'b0;
`ifdef HIT_BLINK_EN
    blink_d = blink_q;
`endif
    case (state_d)
      ARMED: vis_d = 1'b1;
      INVULN: begin
`ifdef HIT_BLINK_EN
        if (state_q != INVULN) begin
          // Entering invulnerability: start hidden with a fresh half-period.
          vis_d   = 1'b0;
          blink_d = '0;
        end else if (tick) begin
          if (blink_q == BLINK_LAST) begin
            vis_d   = ~vis_q;
            blink_d = '0;
          end else begin
            vis_d   = vis_q;
            blink_d = blink_q + 8'd1;
          end
        end else begin
          vis_d = vis_q;
        end
`else
        vis_d = 1'b1;
`endif
      end
      default: vis_d = 1'b0;
    endcase
  end

  // NOTE: clr is sampled on the clock edge only (synchronous reset), and all
  // state updates use non-blocking assignments so every flop sees the
  // pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (clr) begin
      state_q     <= IDLE;
      dec_pulse_q <= 1'b0;
      cnt_q       <= '0;
      vis_q       <= 1'b0;
`ifdef HIT_BLINK_EN
      blink_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dec_pulse_q <= dec_pulse_d;
      cnt_q       <= cnt_d;
      vis_q       <= vis_d;
`ifdef HIT_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  assign dec_pulse    = dec_pulse_q;
  assign invuln       = (state_q == INVULN);
  assign game_over    = (state_q == OVER);
  assign ship_visible = vis_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hit_manager.sv
// Self-checking bench for hit_manager. dut_a (INVULN_TICKS=4) covers the hit,
// lives and reset scenarios; dut_b (INVULN_TICKS=8, BLINK_TICKS=2) shares the
// same inputs and covers the visibility pattern. dec_pulse of dut_a is
// checked by a scoreboard: each expected pulse cycle is queued when the
// colliding stimulus is driven and popped when a pulse appears.

module tb_hit_manager;

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       collision = 1'b0;
  logic       lives_zero;
  int         lives = 3;

  logic       a_dec, a_inv, a_vis, a_go;
  logic [1:0] a_state;
  logic       b_dec, b_inv, b_vis, b_go;
  logic [1:0] b_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_q[$];

`ifdef HIT_BLINK_EN
  localparam bit   BLINK_ON  = 1'b1;
  localparam logic VIS_ENTRY = 1'b0;
`else
  localparam bit   BLINK_ON  = 1'b0;
  localparam logic VIS_ENTRY = 1'b1;
`endif

  // Lives counter model: decrements on the edge that samples dec_pulse.
  assign lives_zero = (lives == 0);

  always #5 clock = ~clock;

  hit_manager #(.INVULN_TICKS(4), .BLINK_TICKS(2), .CNT_W(8)) dut_a (
    .clock(clock), .clr(clr), .start(start), .tick(tick),
    .collision(collision), .lives_zero(lives_zero),
    .dec_pulse(a_dec), .invuln(a_inv), .ship_visible(a_vis),
    .game_over(a_go), .state(a_state)
  );

  hit_manager #(.INVULN_TICKS(8), .BLINK_TICKS(2), .CNT_W(8)) dut_b (
    .clock(clock), .clr(clr), .start(start), .tick(tick),
    .collision(collision), .lives_zero(lives_zero),
    .dec_pulse(b_dec), .invuln(b_inv), .ship_visible(b_vis),
    .game_over(b_go), .state(b_state)
  );

  function automatic logic [5:0] obs_a();
    return {a_state, a_dec, a_inv, a_vis, a_go};
  endfunction

  function automatic logic [5:0] obs_b();
    return {b_state, b_dec, b_inv, b_vis, b_go};
  endfunction

  // One clock: advance the lives model, sample 1 time unit after the edge and
  // match any dec_pulse of dut_a against the scoreboard.
  task automatic cycle();
    logic dp;
    int   e;
    dp = a_dec;
    @(posedge clock);
    #1;
    cyc++;
    if (dp === 1'b1 && lives > 0) lives--;
    if (a_dec === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dec_pulse_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e !== cyc) begin
          errors++;
          $display("FAIL dec_pulse_timing: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  endtask

  task automatic expect_pulse_next();
    exp_q.push_back(cyc + 1);
  endtask

  // Tick on one edge, quiet on the next (ticks never on consecutive cycles).
  task automatic tick_pair();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulse(s) never seen", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset_start();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    clr = 1'b1;
    start = 1'b1;
    cycle();
    cycle();
    got = obs_a();
    checks++;
    if (got !== 6'b00_0_0_0_0) begin
      errors++;
      $display("FAIL reset_a: got %b want %b", got, 6'b00_0_0_0_0);
    end
    got = obs_b();
    checks++;
    if (got !== 6'b00_0_0_0_0) begin
      errors++;
      $display("FAIL reset_b: got %b want %b", got, 6'b00_0_0_0_0);
    end
    clr = 1'b0;
    cycle();
    start = 1'b0;
    got = obs_a();
    checks++;
    if (got !== 6'b01_0_0_1_0) begin
      errors++;
      $display("FAIL start_arms: got %b want %b", got, 6'b01_0_0_1_0);
    end
  endtask

  task automatic test_invuln_hold();
    logic [5:0] got;
    logic [3:0] st;
    lives = 3;
    collision = 1'b1;
    expect_pulse_next();
    cycle();
    got = obs_a();
    checks++;
    if (got !== {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0}) begin
      errors++;
      $display("FAIL hold_entry: got %b want %b", got, {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      st = {a_state, a_inv, a_vis};
      checks++;
      if (i < 3) begin
        if (st[3:1] !== 3'b10_1) begin
          errors++;
          $display("FAIL hold_tick%0d: state/invuln %b want 101", i + 1, st[3:1]);
        end
      end else begin
        if (st !== 4'b01_0_1) begin
          errors++;
          $display("FAIL hold_exit: state/invuln/vis %b want 0101", st);
        end
        // Collision is still high: the next edge is a fresh hit.
        expect_pulse_next();
      end
      cycle();
    end
    got = obs_a();
    checks++;
    if (got !== {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0}) begin
      errors++;
      $display("FAIL hold_rehit: got %b want %b", got, {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0});
    end
    collision = 1'b0;
    for (int i = 0; i < 4; i++) tick_pair();
    checks++;
    if (a_state !== 2'b01) begin
      errors++;
      $display("FAIL hold_rearm: state %b want 01", a_state);
    end
    check_sb_empty("hold_pulses");
  endtask

  task automatic test_lives_to_zero();
    logic [5:0] got;
    do_reset_start();
    lives = 3;
    for (int h = 0; h < 3; h++) begin
      collision = 1'b1;
      expect_pulse_next();
      cycle();
      collision = 1'b0;
      if (h < 2) begin
        for (int i = 0; i < 4; i++) tick_pair();
        checks++;
        if (a_state !== 2'b01) begin
          errors++;
          $display("FAIL lives_rearm%0d: state %b want 01", h + 1, a_state);
        end
      end
    end
    // Cycle N+2: lives_zero only now visible, DUT has not seen it yet.
    cycle();
    checks++;
    if ({a_state, a_go} !== 3'b10_0) begin
      errors++;
      $display("FAIL lives_wait: state/over %b want 100", {a_state, a_go});
    end
    cycle();
    got = obs_a();
    checks++;
    if (got !== 6'b11_0_0_0_1) begin
      errors++;
      $display("FAIL lives_over: got %b want %b", got, 6'b11_0_0_0_1);
    end
    check_sb_empty("lives_pulses");
    lives = 3;
    start = 1'b1;
    cycle();
    start = 1'b0;
    got = obs_a();
    checks++;
    if (got !== 6'b01_0_0_1_0) begin
      errors++;
      $display("FAIL over_restart: got %b want %b", got, 6'b01_0_0_1_0);
    end
  endtask

  task automatic test_zero_beats_collision();
    logic [5:0] got;
    lives = 0;
    collision = 1'b1;
    cycle();
    got = obs_a();
    checks++;
    if (got !== 6'b11_0_0_0_1) begin
      errors++;
      $display("FAIL zero_vs_hit: got %b want %b", got, 6'b11_0_0_0_1);
    end
    cycle();
    collision = 1'b0;
    lives = 3;
    check_sb_empty("zero_vs_hit_pulses");
  endtask

  task automatic test_clr_mid_invuln();
    logic [5:0] got;
    do_reset_start();
    lives = 3;
    collision = 1'b1;
    expect_pulse_next();
    cycle();
    collision = 1'b0;
    cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    got = obs_a();
    checks++;
    if (got !== 6'b00_0_0_0_0) begin
      errors++;
      $display("FAIL clr_invuln: got %b want %b", got, 6'b00_0_0_0_0);
    end
    // clr on the same edge as a hit: the pulse never appears.
    start = 1'b1;
    cycle();
    start = 1'b0;
    collision = 1'b1;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    collision = 1'b0;
    got = obs_a();
    checks++;
    if (got !== 6'b00_0_0_0_0) begin
      errors++;
      $display("FAIL clr_drop_pulse: got %b want %b", got, 6'b00_0_0_0_0);
    end
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    got = obs_a();
    checks++;
    if (got !== 6'b01_0_0_1_0) begin
      errors++;
      $display("FAIL clr_rearm: got %b want %b", got, 6'b01_0_0_1_0);
    end
    check_sb_empty("clr_pulses");
  endtask

  task automatic test_blink();
    logic [5:0] got;
    logic       want;
    do_reset_start();
    lives = 9;
    collision = 1'b1;
    expect_pulse_next();
    cycle();
    collision = 1'b0;
    got = obs_b();
    checks++;
    if (got !== {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0}) begin
      errors++;
      $display("FAIL blink_entry: got %b want %b", got, {2'b10, 1'b1, 1'b1, VIS_ENTRY, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      want = BLINK_ON ? (((i / 2) % 2) == 1) : 1'b1;
      checks++;
      if ({b_state, b_vis} !== {2'b10, want}) begin
        errors++;
        $display("FAIL blink_tick%0d: state/vis %b want %b", i + 1, {b_state, b_vis}, {2'b10, want});
      end
      tick_pair();
    end
    got = obs_b();
    checks++;
    if (got !== 6'b01_0_0_1_0) begin
      errors++;
      $display("FAIL blink_exit: got %b want %b", got, 6'b01_0_0_1_0);
    end
    check_sb_empty("blink_pulses");
  endtask

  initial begin
    test_reset();
    test_invuln_hold();
    test_lives_to_zero();
    test_zero_beats_collision();
    test_clr_mid_invuln();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
